// File: rtl/native_bus_pkg.sv
// Shared definitions for the native-bus memory arbiter: FSM encoding,
// requester indices and default widths.
package native_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_BUSY = 2'b01,
    ARB_DONE = 2'b10
  } arb_state_e;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  localparam int DEF_AW      = 8;
  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/native_bus_if.sv
// Native memory bus: chip select, write/read strobes and address/data, with a
// ready handshake and a timeout error indication.
interface native_bus_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cs;
  logic          we;
  logic          re;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          err;

  // master issues the access, slave completes it
  modport master (output cs, we, re, addr, wdata, input  rdata, ready, err);
  modport slave  (input  cs, we, re, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/native_arb_timer.sv
// Saturating watchdog for the arbiter's BUSY phase; expire_o flags the last
// permitted BUSY cycle. TIMEOUT=0 disables expiry.
module native_arb_timer
  import native_bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST   = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit            ENABLE = (TIMEOUT != 0);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = ENABLE && en_i && (cnt_q == LAST);

endmodule

// File: rtl/native_mem_arbiter.sv
// Round-robin arbiter giving two native-bus requesters access to one memory
// port; the grant is held until ready or a watchdog timeout.
module native_mem_arbiter
  import native_bus_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         resetn,
  native_bus_if.slave  m0,
  native_bus_if.slave  m1,
  native_bus_if.master mem,
  output logic [1:0]   grant
);

  arb_state_e    state_q;
  logic [1:0]    grant_q;
  logic          last_q;
  logic [1:0]    ready_q;
  logic [1:0]    err_q;
  logic [DW-1:0] rdata_q [2];

  logic req0, req1, busy, owner, expire;

  assign req0  = m0.cs & (m0.we | m0.re);
  assign req1  = m1.cs & (m1.we | m1.re);
  assign busy  = (state_q == ARB_BUSY);
  assign owner = grant_q[1];

  native_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .clr_i    (!busy),
    .en_i     (busy),
    .expire_o (expire)
  );

  // NOTE: every output gets a default first so this block cannot infer a latch.
  always_comb begin
    mem.cs    = 1'b0;
    mem.we    = 1'b0;
    mem.re    = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    if (grant_q[0]) begin
      mem.cs    = 1'b1;
      mem.we    = m0.we;
      mem.re    = m0.re & ~m0.we;
      mem.addr  = m0.addr;
      mem.wdata = m0.wdata;
    end else if (grant_q[1]) begin
      mem.cs    = 1'b1;
      mem.we    = m1.we;
      mem.re    = m1.re & ~m1.we;
      mem.addr  = m1.addr;
      mem.wdata = m1.wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      last_q        <= 1'(REQ1);
      ready_q       <= '0;
      err_q         <= '0;
      // NOTE: the read-data array is only two words, so it is reset
      // like ordinary registers rather than left as uninitialised storage.
      rdata_q[REQ0] <= '0;
      rdata_q[REQ1] <= '0;
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      case (state_q)
        ARB_IDLE: begin
          // tie goes to the requester that was not served last
          if (req0 && (!req1 || last_q == 1'(REQ1))) begin
            grant_q <= 2'b01;
            state_q <= ARB_BUSY;
          end else if (req1) begin
            grant_q <= 2'b10;
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (mem.ready) begin
            ready_q[owner] <= 1'b1;
            if (mem.re) rdata_q[owner] <= mem.rdata;
            last_q  <= owner;
            grant_q <= '0;
            state_q <= ARB_DONE;
          end else if (expire) begin
            err_q[owner] <= 1'b1;
            last_q  <= owner;
            grant_q <= '0;
            state_q <= ARB_DONE;
          end
        end
        ARB_DONE: state_q <= ARB_IDLE;
        default: begin
          grant_q <= '0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign m0.ready = ready_q[REQ0];
  assign m0.err   = err_q[REQ0];
  assign m0.rdata = rdata_q[REQ0];
  assign m1.ready = ready_q[REQ1];
  assign m1.err   = err_q[REQ1];
  assign m1.rdata = rdata_q[REQ1];

endmodule

// File: tb/tb_native_mem_arbiter.sv
// Self-checking bench for native_mem_arbiter: directed scenarios plus a random
// phase, all predicted by a transaction-level round-robin model.
module tb_native_mem_arbiter;
  import native_bus_pkg::*;

  localparam int TO    = 4;
  localparam int NEVER = 255;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] grant;

  native_bus_if #(.AW(8), .DW(8)) m0_if ();
  native_bus_if #(.AW(8), .DW(8)) m1_if ();
  native_bus_if #(.AW(8), .DW(8)) mem_if ();

  native_mem_arbiter #(.AW(8), .DW(8), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .m0     (m0_if),
    .m1     (m1_if),
    .mem    (mem_if),
    .grant  (grant)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic re; logic [7:0] addr; logic [7:0] wdata;} txn_t;
  typedef struct {int who; logic err; logic [7:0] rdata; int busy;} ev_t;

  txn_t       rq0[$], rq1[$];
  int         lat_q[$];
  logic [7:0] mrd_q[$];
  ev_t        exp_q[$];
  logic [1:0] gtrace[$];

  int         total = 0, bad = 0;
  int         pl_last;
  logic [7:0] pl_rd[2], mdl_rd[2];
  int         pulses[2];
  bit         in_acc = 0;
  int         bcnt = 0, cur_lat = 0;
  logic [7:0] cur_rd = 8'h00;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(int who);
    txn_t t = '{default: '0};
    bit   v;
    v = (who == 0) ? (rq0.size() != 0) : (rq1.size() != 0);
    if (v) t = (who == 0) ? rq0[0] : rq1[0];
    if (who == 0) begin
      m0_if.cs = v; m0_if.we = t.we; m0_if.re = t.re; m0_if.addr = t.addr; m0_if.wdata = t.wdata;
    end else begin
      m1_if.cs = v; m1_if.we = t.we; m1_if.re = t.re; m1_if.addr = t.addr; m1_if.wdata = t.wdata;
    end
  endtask

  // Plans the outcome of every queued transaction: who is served in which
  // order, ready or timeout, and the read data each requester then holds.
  function automatic void predict();
    txn_t       a[$], b[$], t;
    int         lq[$], who, lat;
    logic [7:0] dq[$], d;
    bit         err;
    a = rq0; b = rq1; lq = lat_q; dq = mrd_q;
    while (a.size() != 0 || b.size() != 0) begin
      if (a.size() != 0 && b.size() != 0) who = (pl_last == 0) ? 1 : 0;
      else who = (a.size() != 0) ? 0 : 1;
      t   = (who == 0) ? a.pop_front() : b.pop_front();
      lat = lq.pop_front();
      d   = dq.pop_front();
      err = (lat >= TO);
      if (!err && t.re && !t.we) pl_rd[who] = d;
      exp_q.push_back('{who, err, pl_rd[who], err ? TO : lat + 1});
      pl_last = who;
    end
  endfunction

  function automatic void clear_model();
    exp_q.delete();
    pl_last = 1;
    pl_rd   = '{8'h00, 8'h00};
    mdl_rd  = '{8'h00, 8'h00};
    pulses  = '{0, 0};
    in_acc  = 0;
  endfunction

  // One clock cycle seen from the negative edge: memory responds, bus and
  // pulses are compared against the plan, and requesters advance.
  task automatic tick();
    txn_t       t;
    ev_t        ev;
    logic [1:0] pm;
    int         who;
    @(negedge clk);
    gtrace.push_back(grant);
    if (mem_if.cs) begin
      if (!in_acc) begin
        in_acc = 1;
        bcnt   = 0;
        check("mem_access_planned", 32'(lat_q.size() != 0), 32'd1);
        if (lat_q.size() != 0) begin
          cur_lat = lat_q.pop_front();
          cur_rd  = mrd_q.pop_front();
        end
      end else begin
        bcnt++;
      end
    end else begin
      in_acc = 0;
    end
    mem_if.ready = mem_if.cs && (bcnt == cur_lat);
    mem_if.rdata = mem_if.ready ? cur_rd : ~cur_rd;

    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    if (grant != 2'b00) begin
      check("grant_planned", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        who = exp_q[0].who;
        t   = (who == 0) ? rq0[0] : rq1[0];
        check("grant_owner", 32'(grant), (who == 0) ? 32'd1 : 32'd2);
        check("mem_cs", 32'(mem_if.cs), 32'd1);
        check("mem_we", 32'(mem_if.we), 32'(t.we));
        check("mem_re", 32'(mem_if.re), 32'(t.re & ~t.we));
        check("mem_addr", 32'(mem_if.addr), 32'(t.addr));
        check("mem_wdata", 32'(mem_if.wdata), 32'(t.wdata));
      end
    end else begin
      check("mem_idle", 32'({mem_if.cs, mem_if.we, mem_if.re, mem_if.addr, mem_if.wdata}), 32'd0);
    end

    check("ready_err_excl", 32'((m0_if.ready & m0_if.err) | (m1_if.ready & m1_if.err)), 32'd0);
    pm = {m1_if.ready | m1_if.err, m0_if.ready | m0_if.err};
    if (pm != 2'b00) begin
      check("pulse_planned", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        check("pulse_owner", 32'(pm), (ev.who == 0) ? 32'd1 : 32'd2);
        check("pulse_err", 32'((ev.who == 0) ? m0_if.err : m1_if.err), 32'(ev.err));
        check("pulse_ready", 32'((ev.who == 0) ? m0_if.ready : m1_if.ready), 32'(!ev.err));
        check("busy_cycles", 32'(bcnt + 1), 32'(ev.busy));
        mdl_rd[ev.who] = ev.rdata;
        pulses[ev.who]++;
        if (ev.who == 0) rq0.delete(0); else rq1.delete(0);
        drive_req(ev.who);
      end
    end
    check("m0_rdata", 32'(m0_if.rdata), 32'(mdl_rd[0]));
    check("m1_rdata", 32'(m1_if.rdata), 32'(mdl_rd[1]));
  endtask

  task automatic run(int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_in_budget", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic reset_seq();
    resetn = 1'b0;
    rq0.delete(); rq1.delete(); lat_q.delete(); mrd_q.delete();
    drive_req(0); drive_req(1);
    mem_if.ready = 1'b0;
    #3;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_mem_cs", 32'(mem_if.cs), 32'd0);
    check("rst_pulses", 32'({m0_if.ready, m0_if.err, m1_if.ready, m1_if.err}), 32'd0);
    check("rst_rdata", 32'({m0_if.rdata, m1_if.rdata}), 32'd0);
    clear_model();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic push_txn(int who, logic we, logic re, logic [7:0] addr, logic [7:0] wdata,
                          int lat, logic [7:0] rd);
    if (who == 0) rq0.push_back('{we, re, addr, wdata});
    else          rq1.push_back('{we, re, addr, wdata});
    lat_q.push_back(lat);
    mrd_q.push_back(rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int first;
    logic [1:0] g_exp;
    mem_if.err   = 1'b0;
    mem_if.rdata = 8'h00;
    reset_seq();

    // cs without a strobe must be ignored
    m0_if.cs = 1'b1;
    repeat (4) tick();
    check("cs_only_ignored", 32'(grant), 32'd0);
    drive_req(0);

    // single write by requester 0, ready on the third BUSY cycle
    push_txn(0, 1'b1, 1'b0, 8'h10, 8'hA5, 2, 8'h00);
    predict(); drive_req(0); run(50);

    // single read by requester 1, one wait cycle
    push_txn(1, 1'b0, 1'b1, 8'h20, 8'h00, 1, 8'h3C);
    predict(); drive_req(1); run(50);
    check("m1_read_data", 32'(m1_if.rdata), 32'h3C);
    check("m0_rdata_kept", 32'(m0_if.rdata), 32'h00);

    // timeout on requester 0 with requester 1 waiting
    push_txn(0, 1'b0, 1'b1, 8'h30, 8'h00, NEVER, 8'hEE);
    push_txn(1, 1'b1, 1'b0, 8'h31, 8'h5A, 0, 8'h00);
    predict(); drive_req(0); drive_req(1); run(50);

    // ready on the very cycle the watchdog expires
    push_txn(0, 1'b0, 1'b1, 8'h40, 8'h00, TO - 1, 8'h99);
    predict(); drive_req(0); run(50);
    check("expiry_ready_data", 32'(m0_if.rdata), 32'h99);

    // contention from reset: continuous writes, single-cycle ready
    reset_seq();
    for (int i = 0; i < 4; i++) begin
      push_txn(0, 1'b1, 1'b0, 8'(8'h50 + i), 8'(i), 0, 8'h00);
      push_txn(1, 1'b1, 1'b0, 8'(8'h60 + i), 8'(8'h80 + i), 0, 8'h00);
    end
    predict(); gtrace.delete(); drive_req(0); drive_req(1); run(200);
    first = 0;
    while (first < gtrace.size() && gtrace[first] == 2'b00) first++;
    check("grant_trace_len", 32'(gtrace.size() >= first + 24), 32'd1);
    for (int k = 0; k < 24 && first + k < gtrace.size(); k++) begin
      g_exp = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
      check("grant_seq", 32'(gtrace[first + k]), 32'(g_exp));
    end
    check("m0_ready_count", 32'(pulses[0]), 32'd4);
    check("m1_ready_count", 32'(pulses[1]), 32'd4);

    // random mixed traffic on both requesters
    for (int i = 0; i < 24; i++) begin
      int kind, lat;
      kind = $urandom_range(0, 2);
      lat  = $urandom_range(0, 6);
      if (lat == 6) lat = NEVER;
      push_txn(i % 2, kind != 1, kind != 0, 8'($urandom), 8'($urandom), lat, 8'($urandom));
    end
    predict(); drive_req(0); drive_req(1); run(600);

    // asynchronous reset in the middle of a BUSY phase
    push_txn(0, 1'b0, 1'b1, 8'h44, 8'h00, NEVER, 8'h11);
    lat_q.push_back(1);
    mrd_q.push_back(8'h77);
    predict(); drive_req(0);
    for (int n = 0; n < 10 && grant == 2'b00; n++) tick();
    check("pre_reset_granted", 32'(grant), 32'd1);
    tick();
    #2 resetn = 1'b0;
    #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_mem_cs", 32'(mem_if.cs), 32'd0);
    check("midrst_pulses", 32'({m0_if.ready, m0_if.err}), 32'd0);
    check("midrst_rdata", 32'(m0_if.rdata), 32'd0);
    clear_model();
    repeat (2) tick();
    resetn = 1'b1;
    predict(); run(50);
    check("rerun_read_data", 32'(m0_if.rdata), 32'h77);
    check("rerun_ready_count", 32'(pulses[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
